axil_irq_target: RTL and testbench
==================================

// Module: axil_irq_target
// PURPOSE
//  AXI4-Lite slave terminating the interrupt-notification writes from an IRQ-forwarding master.
//  Holds a 1-bit interrupt level register at base_addr_p and drives it out as irq_o.
//  Sits on the host-side AXI-Lite fabric in front of a PLIC source or a PS interrupt pin.
//  Single outstanding write and single outstanding read; the read path returns the current level.
// PARAMETERS
//  axil_data_width_p  32        AXI-Lite data width (>=32)
//  axil_addr_width_p  32        AXI-Lite address width
//  base_addr_p        'h30_a000 byte address of the IRQ level register
// PORTS
//  clk_i              in   1     clock
//  reset_i            in   1     synchronous, active-high reset
//  s_axil_awaddr_i    in   A     write address (A = axil_addr_width_p)
//  s_axil_awprot_i    in   3     ignored
//  s_axil_awvalid_i   in   1     / s_axil_awready_o out 1
//  s_axil_wdata_i     in   D     write data (D = axil_data_width_p)
//  s_axil_wstrb_i     in   D/8   byte strobes
//  s_axil_wvalid_i    in   1     / s_axil_wready_o  out 1
//  s_axil_bresp_o     out  2     OKAY=2'b00, SLVERR=2'b10
//  s_axil_bvalid_o    out  1     / s_axil_bready_i  in  1
//  s_axil_araddr_i    in   A     read address
//  s_axil_arprot_i    in   3     ignored
//  s_axil_arvalid_i   in   1     / s_axil_arready_o out 1
//  s_axil_rdata_o     out  D     read data
//  s_axil_rresp_o     out  2     OKAY/SLVERR
//  s_axil_rvalid_o    out  1     / s_axil_rready_i  in  1
//  irq_o              out  1     registered interrupt level
// BEHAVIOUR
//  Reset: irq_o=0, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0; awready=wready=arready=1.
//  Reset mid-transaction discards captured AW/W/AR and pending B/R; no response is issued.
//  Write path: AW and W captured independently into aw_full_r / w_full_r (holding addr/data/strb).
//   awready_o = ~aw_full_r & ~bvalid_r; wready_o = ~w_full_r & ~bvalid_r (combinational from regs).
//   Commit cycle: aw_full_r & w_full_r & ~bvalid_r. At commit, both full flags clear, bvalid_r sets.
//   Decode on full address equality; addr==base_addr_p: if wstrb[0] irq_r<=wdata[0], bresp=OKAY;
//    wstrb[0]==0 -> OKAY, no change. Any other address -> SLVERR, no state change.
//   AW+W handshake at cycle T -> irq_o and bvalid visible at T+2. AW at T, W at T+k -> T+k+2.
//   bvalid held with stable bresp until bready; handshake clears bvalid; new AW/W accepted next cycle.
//  Read path: arready_o = ~rvalid_r. AR handshake at T -> rvalid, rdata, rresp registered at T+1.
//   addr==base_addr_p: rdata={0..,irq_r}, OKAY; unmapped: rdata=0, SLVERR. Held until rready.
//  Simultaneous read and write commit in the same cycle: read returns pre-write irq level.
//  Read and write paths are fully independent; no ordering between them.
// CONFIGURATION
//  AXIL_IRQ_TARGET_TOGGLE_COUNT_EN defined: 32-bit read-only counter at base_addr_p+4, reset 0,
//   incremented (wrapping 'hFFFF_FFFF->0) on every level-register commit that changes irq_o.
//   Read returns counter (zero-extended), OKAY; write returns SLVERR, counter unchanged.
//  Undefined: base_addr_p+4 is unmapped (read/write -> SLVERR, rdata=0); no counter logic.
// TESTING
//  Reset, then AW(base)+W(1,strb 'hF) same cycle, bready=1 -> irq_o=1 and bvalid at T+2, bresp=0.
//  W(data 0) at T, AW(base) at T+3 -> no change until T+5; irq_o=0 at T+5; awready/wready low while bvalid.
//  AW('h30_a010)+W(1) -> bresp=2'b10, irq_o unchanged; AR('h30_a010) -> rresp=2'b10, rdata=0.
//  irq_o=1, bready=0 for 10 cycles -> bvalid/bresp stable, awready=wready=0; second AW waits till B done.
//  AR(base) with rready=0 for 5 cycles -> rdata=1 stable, arready=0; same-cycle write 0 -> read returns 1.
//  TOGGLE_COUNT_EN: writes 1,1,0,1 -> read base+4 returns 3; write base+4 -> SLVERR; reset mid-B -> bvalid=0.

Source files
------------

// File: rtl/axil_irq_target_if.sv
// AXI4-Lite bus bundle for the IRQ level target.
// The slave modport is the target's view and the master modport is the initiator's view.
interface axil_irq_target_if #(
    parameter int addr_width_p = 32,
    parameter int data_width_p = 32
);
    logic [addr_width_p-1:0]   awaddr;
    logic [2:0]                awprot;
    logic                      awvalid;
    logic                      awready;
    logic [data_width_p-1:0]   wdata;
    logic [data_width_p/8-1:0] wstrb;
    logic                      wvalid;
    logic                      wready;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;
    logic [addr_width_p-1:0]   araddr;
    logic [2:0]                arprot;
    logic                      arvalid;
    logic                      arready;
    logic [data_width_p-1:0]   rdata;
    logic [1:0]                rresp;
    logic                      rvalid;
    logic                      rready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_irq_target.sv
// AXI4-Lite slave holding a single interrupt level bit at base_addr_p, driven out on irq_o.
// One write and one read may be outstanding; AW and W are captured independently and the
// write commits one cycle after both are held. The read path returns the current level.
// Optional feature: define AXIL_IRQ_TARGET_TOGGLE_COUNT_EN to add a read-only 32-bit counter
// at base_addr_p+4 counting level commits that actually change irq_o.
module axil_irq_target #(
    parameter int                           axil_data_width_p = 32,
    parameter int                           axil_addr_width_p = 32,
    parameter logic [axil_addr_width_p-1:0] base_addr_p       = 'h30_a000
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    axil_irq_target_if.slave        s_axil,
    output logic                    irq_o
);
    localparam int A = axil_addr_width_p;
    localparam int D = axil_data_width_p;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef AXIL_IRQ_TARGET_TOGGLE_COUNT_EN
    localparam logic [A-1:0] cnt_addr_c = base_addr_p + A'(4);
`endif

    // Write address/data holding registers
    logic         aw_full_r;
    logic [A-1:0] aw_addr_r;
    logic         w_full_r;
    logic         w_data0_r;
    logic         w_strb0_r;

    // Write response
    logic         bvalid_r;
    logic [1:0]   bresp_r;

    // Read response
    logic         rvalid_r;
    logic [D-1:0] rdata_r;
    logic [1:0]   rresp_r;

    // Interrupt level
    logic         irq_r;

    logic         aw_hs;
    logic         w_hs;
    logic         ar_hs;
    logic         commit;
    logic         lvl_wr;
    logic [D-1:0] rd_data_c;
    logic [1:0]   rd_resp_c;

    // Only bit 0 of data/strobe and none of the prot bits carry meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{s_axil.awprot, s_axil.arprot,
                             s_axil.wdata[D-1:1], s_axil.wstrb[D/8-1:1]};

    // Only the level register accepts writes; everything else (including the counter) errors.
    function automatic logic [1:0] wr_resp(input logic [A-1:0] addr);
        return (addr == base_addr_p) ? RESP_OKAY : RESP_SLVERR;
    endfunction

    assign s_axil.awready = ~aw_full_r & ~bvalid_r;
    assign s_axil.wready  = ~w_full_r & ~bvalid_r;
    assign s_axil.arready = ~rvalid_r;
    assign s_axil.bvalid  = bvalid_r;
    assign s_axil.bresp   = bresp_r;
    assign s_axil.rvalid  = rvalid_r;
    assign s_axil.rdata   = rdata_r;
    assign s_axil.rresp   = rresp_r;
    assign irq_o          = irq_r;

    assign aw_hs  = s_axil.awvalid & s_axil.awready;
    assign w_hs   = s_axil.wvalid & s_axil.wready;
    assign ar_hs  = s_axil.arvalid & s_axil.arready;
    assign commit = aw_full_r & w_full_r & ~bvalid_r;
    assign lvl_wr = commit & (aw_addr_r == base_addr_p) & w_strb0_r;

    // Write control: full flags, commit into a pending B response, release on bready
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            aw_full_r <= 1'b0;
            w_full_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
        end else begin
            if (aw_hs) aw_full_r <= 1'b1;
            if (w_hs)  w_full_r  <= 1'b1;
            if (commit) begin
                aw_full_r <= 1'b0;
                w_full_r  <= 1'b0;
                bvalid_r  <= 1'b1;
                bresp_r   <= wr_resp(aw_addr_r);
            end else if (bvalid_r && s_axil.bready) begin
                bvalid_r  <= 1'b0;
            end
        end
    end

    // Write payload capture; contents only matter while the matching full flag is set
    always_ff @(posedge clk_i) begin
        if (aw_hs) aw_addr_r <= s_axil.awaddr;
        if (w_hs) begin
            w_data0_r <= s_axil.wdata[0];
            w_strb0_r <= s_axil.wstrb[0];
        end
    end

    // Interrupt level register, updated only by a strobed commit to the level address
    always_ff @(posedge clk_i) begin
        if (reset_i)     irq_r <= 1'b0;
        else if (lvl_wr) irq_r <= w_data0_r;
    end

`ifdef AXIL_IRQ_TARGET_TOGGLE_COUNT_EN
    logic [31:0] toggle_cnt_r;

    // Count level commits that change irq_o; wraps naturally at 32 bits
    always_ff @(posedge clk_i) begin
        if (reset_i)                             toggle_cnt_r <= 32'd0;
        else if (lvl_wr && (w_data0_r != irq_r)) toggle_cnt_r <= toggle_cnt_r + 32'd1;
    end

    // Read decode: level register, toggle counter, otherwise error with zero data
    always_comb begin
        rd_data_c = '0;
        rd_resp_c = RESP_SLVERR;
        if (s_axil.araddr == base_addr_p) begin
            rd_data_c = D'(irq_r);
            rd_resp_c = RESP_OKAY;
        end else if (s_axil.araddr == cnt_addr_c) begin
            rd_data_c = D'(toggle_cnt_r);
            rd_resp_c = RESP_OKAY;
        end
    end
`else
    // Read decode: level register, otherwise error with zero data
    always_comb begin
        rd_data_c = '0;
        rd_resp_c = RESP_SLVERR;
        if (s_axil.araddr == base_addr_p) begin
            rd_data_c = D'(irq_r);
            rd_resp_c = RESP_OKAY;
        end
    end
`endif

    // Read response register; samples the level before any same-cycle write commit lands
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rvalid_r <= 1'b0;
            rdata_r  <= '0;
            rresp_r  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid_r <= 1'b1;
            rdata_r  <= rd_data_c;
            rresp_r  <= rd_resp_c;
        end else if (rvalid_r && s_axil.rready) begin
            rvalid_r <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axil_irq_target.sv
// Directed bench for axil_irq_target: a table of single transactions plus hand-written
// sequences for split AW/W, B backpressure, R backpressure with a concurrent write, and reset.
module tb_axil_irq_target;
    localparam logic [31:0] BASE = 32'h0030_a000;

    logic clk = 1'b0;
    logic rst;
    logic irq;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axil_irq_target_if #(.addr_width_p(32), .data_width_p(32)) bus ();

    axil_irq_target #(
        .axil_data_width_p(32),
        .axil_addr_width_p(32),
        .base_addr_p      (BASE)
    ) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .s_axil (bus.slave),
        .irq_o  (irq)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic        exp_irq;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // AW and W presented together; reports whether B arrived exactly two cycles after handshake.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output logic got_b, output logic [1:0] resp);
        int   n;
        logic early;
        n = 0;
        @(negedge clk);
        bus.awaddr = addr; bus.awvalid = 1'b1;
        bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
        bus.bready = 1'b1;
        while (!(bus.awready && bus.wready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        early = bus.bvalid;
        @(negedge clk);
        got_b = !early && bus.bvalid;
        resp  = bus.bresp;
    endtask

    // AR presented with rready high; reports whether R arrived one cycle after handshake.
    task automatic do_read(input logic [31:0] addr, output logic got_r,
                           output logic [1:0] resp, output logic [31:0] data);
        int n;
        n = 0;
        @(negedge clk);
        bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b1;
        while (!bus.arready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus.arvalid = 1'b0;
        got_r = bus.rvalid;
        resp  = bus.rresp;
        data  = bus.rdata;
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        got;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic        hold_ok;
        int          n;

        vecs[0]  = '{1'b1, BASE,           32'h1,         4'hF, 2'b00, 1'b1, 32'h0};
        vecs[1]  = '{1'b0, BASE,           32'h0,         4'h0, 2'b00, 1'b1, 32'h1};
        vecs[2]  = '{1'b1, BASE,           32'h0,         4'hE, 2'b00, 1'b1, 32'h0};
        vecs[3]  = '{1'b1, BASE,           32'h0,         4'h1, 2'b00, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, BASE,           32'h0,         4'h0, 2'b00, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 32'h0030_a010,  32'h1,         4'hF, 2'b10, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 32'h0030_a010,  32'h0,         4'h0, 2'b10, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 32'h0030_a004,  32'h1,         4'hF, 2'b10, 1'b0, 32'h0};
`ifdef AXIL_IRQ_TARGET_TOGGLE_COUNT_EN
        vecs[8]  = '{1'b0, 32'h0030_a004,  32'h0,         4'h0, 2'b00, 1'b0, 32'h2};
`else
        vecs[8]  = '{1'b0, 32'h0030_a004,  32'h0,         4'h0, 2'b10, 1'b0, 32'h0};
`endif
        vecs[9]  = '{1'b1, BASE,           32'hFFFF_FFFE, 4'hF, 2'b00, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 32'h0030_a001,  32'h1,         4'hF, 2'b10, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 32'h0030_a001,  32'h0,         4'h0, 2'b10, 1'b0, 32'h0};
        vecs[12] = '{1'b1, BASE,           32'h3,         4'hF, 2'b00, 1'b1, 32'h0};
        vecs[13] = '{1'b0, BASE,           32'h0,         4'h0, 2'b00, 1'b1, 32'h1};

        rst = 1'b1;
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_irq",     32'(irq),         32'h0);
        check("rst_bvalid",  32'(bus.bvalid),  32'h0);
        check("rst_rvalid",  32'(bus.rvalid),  32'h0);
        check("rst_bresp",   32'(bus.bresp),   32'h0);
        check("rst_rresp",   32'(bus.rresp),   32'h0);
        check("rst_rdata",   bus.rdata,        32'h0);
        check("rst_awready", 32'(bus.awready), 32'h1);
        check("rst_wready",  32'(bus.wready),  32'h1);
        check("rst_arready", 32'(bus.arready), 32'h1);

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, got, resp);
                check($sformatf("v%0d_bvalid_t2", i), 32'(got),  32'h1);
                check($sformatf("v%0d_bresp", i),     32'(resp), 32'(vecs[i].exp_resp));
                check($sformatf("v%0d_irq", i),       32'(irq),  32'(vecs[i].exp_irq));
            end else begin
                do_read(vecs[i].addr, got, resp, rdata);
                check($sformatf("v%0d_rvalid_t1", i), 32'(got),  32'h1);
                check($sformatf("v%0d_rresp", i),     32'(resp), 32'(vecs[i].exp_resp));
                check($sformatf("v%0d_rdata", i),     rdata,     vecs[i].exp_rdata);
                check($sformatf("v%0d_irq", i),       32'(irq),  32'(vecs[i].exp_irq));
            end
        end

        // W first, AW three cycles later; irq is 1 going in and must fall only at T+5.
        @(negedge clk);
        bus.bready = 1'b0;
        bus.wdata = 32'h0; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(negedge clk);                       // cycle T+1
        bus.wvalid = 1'b0;
        check("split_wready_full", 32'(bus.wready),  32'h0);
        check("split_awready",     32'(bus.awready), 32'h1);
        @(negedge clk);                       // cycle T+2
        @(negedge clk);                       // cycle T+3
        bus.awaddr = BASE; bus.awvalid = 1'b1;
        @(negedge clk);                       // cycle T+4
        bus.awvalid = 1'b0;
        check("split_irq_t4",    32'(irq),        32'h1);
        check("split_bvalid_t4", 32'(bus.bvalid), 32'h0);
        @(negedge clk);                       // cycle T+5
        check("split_irq_t5",    32'(irq),         32'h0);
        check("split_bvalid_t5", 32'(bus.bvalid),  32'h1);
        check("split_bresp",     32'(bus.bresp),   32'h0);
        check("split_awready_b", 32'(bus.awready), 32'h0);
        check("split_wready_b",  32'(bus.wready),  32'h0);

        // Hold B for 10 cycles with a second AW waiting; nothing may be accepted meanwhile.
        bus.awaddr = BASE; bus.awvalid = 1'b1;
        hold_ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (!bus.bvalid || bus.bresp != 2'b00 || bus.awready || bus.wready) hold_ok = 1'b0;
        end
        check("hold_b_stable", 32'(hold_ok), 32'h1);
        bus.bready = 1'b1;
        @(negedge clk);
        check("hold_b_released", 32'(bus.bvalid),  32'h0);
        check("hold_aw_waited",  32'(bus.awready), 32'h1);
        bus.wdata = 32'h1; bus.wstrb = 4'h1; bus.wvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        check("hold2_irq_t1", 32'(irq), 32'h0);
        @(negedge clk);
        check("hold2_bvalid", 32'(bus.bvalid), 32'h1);
        check("hold2_irq",    32'(irq),        32'h1);

        // Read with rready low while a write of 0 commits in the AR handshake cycle.
        @(negedge clk);
        bus.awaddr = BASE; bus.awvalid = 1'b1;
        bus.wdata = 32'h0; bus.wstrb = 4'hF; bus.wvalid = 1'b1; bus.bready = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        bus.araddr = BASE; bus.arvalid = 1'b1; bus.rready = 1'b0;
        @(negedge clk);
        bus.arvalid = 1'b0;
        check("rd_race_rvalid", 32'(bus.rvalid), 32'h1);
        check("rd_race_rdata",  bus.rdata,       32'h1);
        check("rd_race_irq",    32'(irq),        32'h0);
        hold_ok = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (!bus.rvalid || bus.rdata != 32'h1 || bus.rresp != 2'b00 || bus.arready) hold_ok = 1'b0;
        end
        check("rd_hold_stable", 32'(hold_ok), 32'h1);
        bus.rready = 1'b1;
        @(negedge clk);
        check("rd_released",     32'(bus.rvalid),  32'h0);
        check("rd_arready_back", 32'(bus.arready), 32'h1);

        // Reset while B and R are both pending: both are dropped, level clears.
        @(negedge clk);
        bus.awaddr = BASE; bus.awvalid = 1'b1;
        bus.wdata = 32'h1; bus.wstrb = 4'hF; bus.wvalid = 1'b1; bus.bready = 1'b0;
        bus.araddr = BASE; bus.arvalid = 1'b1; bus.rready = 1'b0;
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        n = 0;
        while (!bus.bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mid_pre_bvalid", 32'(bus.bvalid), 32'h1);
        check("mid_pre_rvalid", 32'(bus.rvalid), 32'h1);
        check("mid_pre_irq",    32'(irq),        32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_bvalid",  32'(bus.bvalid),  32'h0);
        check("mid_rst_rvalid",  32'(bus.rvalid),  32'h0);
        check("mid_rst_irq",     32'(irq),         32'h0);
        check("mid_rst_awready", 32'(bus.awready), 32'h1);
        check("mid_rst_arready", 32'(bus.arready), 32'h1);
        bus.bready = 1'b1; bus.rready = 1'b1;
        @(negedge clk);
        check("mid_rst_no_b", 32'(bus.bvalid), 32'h0);

`ifdef AXIL_IRQ_TARGET_TOGGLE_COUNT_EN
        // After reset the counter is 0; writes 1,1,0,1 change the level three times.
        do_write(BASE, 32'h1, 4'hF, got, resp);
        do_write(BASE, 32'h1, 4'hF, got, resp);
        do_write(BASE, 32'h0, 4'hF, got, resp);
        do_write(BASE, 32'h1, 4'hF, got, resp);
        do_read(BASE + 32'h4, got, resp, rdata);
        check("cnt_rresp", 32'(resp), 32'h0);
        check("cnt_value", rdata,     32'h3);
        do_write(BASE + 32'h4, 32'h0, 4'hF, got, resp);
        check("cnt_wr_bresp", 32'(resp), 32'h2);
        do_read(BASE + 32'h4, got, resp, rdata);
        check("cnt_after_wr", rdata, 32'h3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
